// File: rtl/i2s_pkg.sv
// I2S receiver shared definitions: default geometry and
// the framing state type used by i2s_rx.
package i2s_pkg;

    localparam int I2S_WIDTH_DEF   = 16;
    localparam int I2S_TIMEOUT_DEF = 255;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// I2S receiver front end: 2-FF synchronisers for BCK, WS and DIN
// plus a BCK rising-edge detector on the synchronised clock.
module i2s_rx_sync
    import i2s_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_bck,
    input  logic i_ws,
    input  logic i_din,
    output logic o_bck_rise,
    output logic o_ws,
    output logic o_din
);

    logic [1:0] r_bck_sync;
    logic [1:0] r_ws_sync;
    logic [1:0] r_din_sync;
    logic       r_bck_prev;

    // Two-stage synchronisers and previous synchronised BCK value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bck_sync <= '0;
            r_ws_sync  <= '0;
            r_din_sync <= '0;
            r_bck_prev <= 1'b0;
        end else begin
            r_bck_sync <= {r_bck_sync[0], i_bck};
            r_ws_sync  <= {r_ws_sync[0], i_ws};
            r_din_sync <= {r_din_sync[0], i_din};
            r_bck_prev <= r_bck_sync[1];
        end
    end

    assign o_bck_rise = r_bck_sync[1] & ~r_bck_prev;
    assign o_ws       = r_ws_sync[1];
    assign o_din      = r_din_sync[1];

endmodule

// File: rtl/i2s_rx.sv
// Philips I2S stereo receiver with HUNT/RUN framing and a BCK watchdog.
// Optional averaged mono output when I2S_RX_MONO_EN is defined.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH   = I2S_WIDTH_DEF,
    parameter int TIMEOUT = I2S_TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_i2s_bck,
    input  logic             i_i2s_ws,
    input  logic             i_i2s_din,
    output logic [WIDTH-1:0] o_left_out,
    output logic [WIDTH-1:0] o_right_out,
    output logic             o_sample_strobe,
    output logic             o_locked,
    output logic             o_frame_err
`ifdef I2S_RX_MONO_EN
    ,
    output logic [WIDTH-1:0] o_mono_out
`endif
);

    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    logic             w_bck_rise;
    logic             w_ws;
    logic             w_din;

    i2s_state_e       r_state;
    i2s_state_e       w_state_nx;

    logic             r_ws_prev;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nx;
    logic [TW-1:0]    r_wdog;

    logic             w_ws_toggle;
    logic             w_timeout;
    logic             w_hunt_start;
    logic             w_word_done;
    logic             w_word_err;

    logic             r_done;
    logic             r_done_ch;
    logic             r_done_err;
    logic [WIDTH-1:0] r_done_word;

    logic [WIDTH-1:0] r_stage;
    logic             r_stage_vld;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic             r_strobe;
    logic             r_ferr;
    logic             r_locked;

    i2s_rx_sync u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_bck      (i_i2s_bck),
        .i_ws       (i_i2s_ws),
        .i_din      (i_i2s_din),
        .o_bck_rise (w_bck_rise),
        .o_ws       (w_ws),
        .o_din      (w_din)
    );

    // Edge-time helpers: WS change, next bit count, next shift value, watchdog expiry
    always_comb begin
        w_ws_toggle = w_bck_rise & (w_ws != r_ws_prev);
        w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
        w_shift_nx  = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_shift_nx[WIDTH-1-i] = w_din;
            end
        end
        w_timeout   = ~w_bck_rise & (r_wdog == TW'(TIMEOUT - 1));
    end

    // Framing state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Framing next state: lock onto a right->left boundary, drop out on errors
    always_comb begin
        w_state_nx   = r_state;
        w_hunt_start = 1'b0;
        w_word_done  = 1'b0;
        w_word_err   = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (w_ws_toggle && r_ws_prev) begin
                    w_hunt_start = 1'b1;
                    w_state_nx   = RUN;
                end
            end
            RUN: begin
                if (w_ws_toggle) begin
                    w_word_done = 1'b1;
                    w_word_err  = (w_cnt_inc != CW'(WIDTH));
                end
                if (w_word_err || w_timeout) begin
                    w_state_nx = HUNT;
                end
            end
            default: w_state_nx = HUNT;
        endcase
    end

    // Bit capture, watchdog and registered word-completion event
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ws_prev   <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_wdog      <= TW'(TIMEOUT);
            r_done      <= 1'b0;
            r_done_ch   <= 1'b0;
            r_done_err  <= 1'b0;
            r_done_word <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_bck_rise) begin
                r_ws_prev <= w_ws;
                r_wdog    <= '0;
            end else if (r_wdog != TW'(TIMEOUT)) begin
                r_wdog <= r_wdog + TW'(1);
            end
            if (w_hunt_start || w_word_done) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (r_state == RUN && w_bck_rise) begin
                r_cnt   <= w_cnt_inc;
                r_shift <= w_shift_nx;
            end
            if (w_word_done) begin
                r_done      <= 1'b1;
                r_done_ch   <= r_ws_prev;
                r_done_err  <= w_word_err;
                r_done_word <= w_shift_nx;
            end
        end
    end

    // Left staging, paired output update, strobe/error pulses and lock flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stage     <= '0;
            r_stage_vld <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_strobe    <= 1'b0;
            r_ferr      <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_ferr   <= 1'b0;
            if (r_done) begin
                if (r_done_err) begin
                    r_ferr   <= 1'b1;
                    r_locked <= 1'b0;
                end
                if (!r_done_ch) begin
                    r_stage     <= r_done_word;
                    r_stage_vld <= ~r_done_err;
                end else if (r_stage_vld) begin
                    r_left      <= r_stage;
                    r_right     <= r_done_word;
                    r_strobe    <= ~r_done_err;
                    r_stage_vld <= 1'b0;
                    if (!r_done_err) begin
                        r_locked <= 1'b1;
                    end
                end
            end
            if (w_timeout) begin
                r_locked    <= 1'b0;
                r_stage_vld <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_MONO_EN
    logic [WIDTH:0]   w_mono_sum;
    logic [WIDTH-1:0] r_mono;

    assign w_mono_sum = {r_stage[WIDTH-1], r_stage}
                      + {r_done_word[WIDTH-1], r_done_word};

    // Mono average tracks the stereo pair update
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mono <= '0;
        end else if (r_done && r_done_ch && r_stage_vld) begin
            r_mono <= w_mono_sum[WIDTH:1];
        end
    end

    assign o_mono_out = r_mono;
`endif

    assign o_left_out      = r_left;
    assign o_right_out     = r_right;
    assign o_sample_strobe = r_strobe;
    assign o_locked        = r_locked;
    assign o_frame_err     = r_ferr;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives Philips I2S frames at clk/22
// and compares outputs against a word-level model of the framing rules.
module tb_i2s_rx;

    localparam int W  = 16;
    localparam int TO = 255;

    logic         clk;
    logic         rst_n;
    logic         bck;
    logic         ws;
    logic         din;
    logic [W-1:0] o_left_out;
    logic [W-1:0] o_right_out;
    logic         o_sample_strobe;
    logic         o_locked;
    logic         o_frame_err;
`ifdef I2S_RX_MONO_EN
    logic [W-1:0] o_mono_out;
`endif

    int checks;
    int errors;
    int strb_cnt;
    int ferr_cnt;
    int last_slat;
    int last_flat;

    i2s_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_i2s_bck       (bck),
        .i_i2s_ws        (ws),
        .i_i2s_din       (din),
        .o_left_out      (o_left_out),
        .o_right_out     (o_right_out),
        .o_sample_strobe (o_sample_strobe),
        .o_locked        (o_locked),
        .o_frame_err     (o_frame_err)
`ifdef I2S_RX_MONO_EN
        ,
        .o_mono_out      (o_mono_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_sample_strobe) strb_cnt++;
        if (o_frame_err) ferr_cnt++;
    end

    // Expected output word for an n-bit word: first W bits, left-justified
    function automatic logic [W-1:0] exp_word(input logic [31:0] v, input int n);
        logic [31:0] t;
        if (n >= W) t = v >> (n - W);
        else t = v << (W - n);
        return t[W-1:0];
    endfunction

    // One BCK period (11 clk low, 11 clk high); records pulse latency from the rise
    task automatic send_bit(input logic w, input logic d);
        bck = 1'b0;
        ws  = w;
        din = d;
        repeat (11) @(negedge clk);
        bck = 1'b1;
        last_slat = 0;
        last_flat = 0;
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (o_sample_strobe && last_slat == 0) last_slat = j;
            if (o_frame_err && last_flat == 0) last_flat = j;
        end
    endtask

    // Philips framing: LSB travels with the other channel's WS value
    task automatic send_word(input logic ch, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 1; i--) send_bit(ch, v[i]);
        send_bit(~ch, v[0]);
    endtask

    task automatic send_frame(input logic [31:0] l, input int ln,
                              input logic [31:0] r, input int rn);
        send_word(1'b0, l, ln);
        send_word(1'b1, r, rn);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bck = 1'b0;
        ws = 1'b0;
        din = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_left_out !== '0) begin
            errors++; $display("FAIL reset_left got %h exp 0", o_left_out);
        end
        checks++;
        if (o_right_out !== '0) begin
            errors++; $display("FAIL reset_right got %h exp 0", o_right_out);
        end
        checks++;
        if (o_sample_strobe !== 1'b0) begin
            errors++; $display("FAIL reset_strobe got %b exp 0", o_sample_strobe);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++; $display("FAIL reset_locked got %b exp 0", o_locked);
        end
        checks++;
        if (o_frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr got %b exp 0", o_frame_err);
        end
`ifdef I2S_RX_MONO_EN
        checks++;
        if (o_mono_out !== '0) begin
            errors++; $display("FAIL reset_mono got %h exp 0", o_mono_out);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal;
        int s0;
        int f0;
        s0 = strb_cnt;
        f0 = ferr_cnt;
        // first frame only finds the right->left boundary
        send_frame(32'h1234, 16, 32'hFEDC, 16);
        checks++;
        if (strb_cnt - s0 !== 0) begin
            errors++; $display("FAIL nom_first_strobes got %0d exp 0", strb_cnt - s0);
        end
        send_frame(32'h1234, 16, 32'hFEDC, 16);
        send_frame(32'h1234, 16, 32'hFEDC, 16);
        checks++;
        if (strb_cnt - s0 !== 2) begin
            errors++; $display("FAIL nom_strobes got %0d exp 2", strb_cnt - s0);
        end
        checks++;
        if (o_left_out !== 16'h1234) begin
            errors++; $display("FAIL nom_left got %h exp 1234", o_left_out);
        end
        checks++;
        if (o_right_out !== 16'hFEDC) begin
            errors++; $display("FAIL nom_right got %h exp fedc", o_right_out);
        end
        checks++;
        if (o_locked !== 1'b1) begin
            errors++; $display("FAIL nom_locked got %b exp 1", o_locked);
        end
        checks++;
        if (ferr_cnt - f0 !== 0) begin
            errors++; $display("FAIL nom_ferr got %0d exp 0", ferr_cnt - f0);
        end
        checks++;
        if (last_slat !== 4) begin
            errors++; $display("FAIL nom_latency got %0d exp 4", last_slat);
        end
    endtask

    task automatic test_random;
        logic [15:0] l;
        logic [15:0] r;
        int s0;
        for (int k = 0; k < 12; k++) begin
            l = 16'($urandom);
            r = 16'($urandom);
            s0 = strb_cnt;
            send_frame({16'h0, l}, 16, {16'h0, r}, 16);
            checks++;
            if (strb_cnt - s0 !== 1) begin
                errors++; $display("FAIL rnd_strobe got %0d exp 1", strb_cnt - s0);
            end
            checks++;
            if (o_left_out !== exp_word({16'h0, l}, 16)) begin
                errors++; $display("FAIL rnd_left got %h exp %h", o_left_out, l);
            end
            checks++;
            if (o_right_out !== exp_word({16'h0, r}, 16)) begin
                errors++; $display("FAIL rnd_right got %h exp %h", o_right_out, r);
            end
        end
    endtask

    task automatic test_bad_words;
        logic [15:0] l;
        logic [15:0] p;
        logic [31:0] v20;
        int s0;
        int f0;
        l = 16'($urandom);
        s0 = strb_cnt;
        f0 = ferr_cnt;
        send_frame({16'h0, l}, 16, 32'hABC, 12);
        checks++;
        if (o_right_out !== 16'hABC0) begin
            errors++; $display("FAIL short_right got %h exp abc0", o_right_out);
        end
        checks++;
        if (o_left_out !== l) begin
            errors++; $display("FAIL short_left got %h exp %h", o_left_out, l);
        end
        checks++;
        if (strb_cnt - s0 !== 0 || ferr_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL short_pulses got strb %0d ferr %0d exp 0 1",
                     strb_cnt - s0, ferr_cnt - f0);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++; $display("FAIL short_locked got %b exp 0", o_locked);
        end
        checks++;
        if (last_flat !== 4) begin
            errors++; $display("FAIL short_ferr_latency got %0d exp 4", last_flat);
        end
        // back in HUNT: next frame only re-finds the boundary
        s0 = strb_cnt;
        send_frame(32'h1111, 16, 32'h2222, 16);
        checks++;
        if (strb_cnt - s0 !== 0) begin
            errors++; $display("FAIL hunt_strobe got %0d exp 0", strb_cnt - s0);
        end
        p = 16'($urandom);
        send_frame({16'h0, p}, 16, 32'h5A5A, 16);
        checks++;
        if (strb_cnt - s0 !== 1 || o_left_out !== p || o_locked !== 1'b1) begin
            errors++;
            $display("FAIL relock got strb %0d left %h lock %b exp 1 %h 1",
                     strb_cnt - s0, o_left_out, o_locked, p);
        end
        v20 = 32'($urandom_range(0, 32'hFFFFF));
        f0 = ferr_cnt;
        send_frame(32'h0F0F, 16, v20, 20);
        checks++;
        if (o_right_out !== exp_word(v20, 20)) begin
            errors++;
            $display("FAIL long_right got %h exp %h", o_right_out, exp_word(v20, 20));
        end
        checks++;
        if (ferr_cnt - f0 !== 1 || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL long_err got ferr %0d lock %b exp 1 0",
                     ferr_cnt - f0, o_locked);
        end
    endtask

    task automatic test_timeout;
        int s0;
        int f0;
        send_frame(32'h0001, 16, 32'h0002, 16);
        send_frame(32'hC0DE, 16, 32'hBEEF, 16);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++; $display("FAIL to_prelock got %b exp 1", o_locked);
        end
        s0 = strb_cnt;
        f0 = ferr_cnt;
        // pin rise + 2 synchroniser stages + TIMEOUT edge-free cycles
        for (int j = 12; j <= 300; j++) begin
            @(negedge clk);
            if (j == TO + 2) begin
                checks++;
                if (o_locked !== 1'b1) begin
                    errors++; $display("FAIL to_early got %b exp 1", o_locked);
                end
            end
            if (j == TO + 3) begin
                checks++;
                if (o_locked !== 1'b0) begin
                    errors++; $display("FAIL to_fall got %b exp 0", o_locked);
                end
            end
        end
        checks++;
        if (o_left_out !== 16'hC0DE || o_right_out !== 16'hBEEF) begin
            errors++;
            $display("FAIL to_hold got %h %h exp c0de beef", o_left_out, o_right_out);
        end
        checks++;
        if (strb_cnt - s0 !== 0 || ferr_cnt - f0 !== 0) begin
            errors++;
            $display("FAIL to_pulses got %0d %0d exp 0 0", strb_cnt - s0, ferr_cnt - f0);
        end
    endtask

    task automatic test_midword_start;
        int s0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strb_cnt;
        // tail of a right word: bits 7..1 then LSB with left WS
        send_word(1'b1, 32'hA5, 8);
        checks++;
        if (strb_cnt - s0 !== 0 || o_right_out !== '0) begin
            errors++;
            $display("FAIL mid_early got strb %0d right %h exp 0 0",
                     strb_cnt - s0, o_right_out);
        end
        send_frame(32'h3C3C, 16, 32'h8001, 16);
        checks++;
        if (strb_cnt - s0 !== 1) begin
            errors++; $display("FAIL mid_strobe got %0d exp 1", strb_cnt - s0);
        end
        checks++;
        if (o_left_out !== 16'h3C3C || o_right_out !== 16'h8001) begin
            errors++;
            $display("FAIL mid_pair got %h %h exp 3c3c 8001", o_left_out, o_right_out);
        end
    endtask

    task automatic test_reset_midword;
        logic [31:0] v;
        int s0;
        v = 32'h9876;
        for (int i = 15; i >= 10; i--) send_bit(1'b0, v[i]);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (o_left_out !== '0 || o_right_out !== '0 || o_locked !== 1'b0 ||
            o_sample_strobe !== 1'b0 || o_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outs got %h %h %b %b %b exp all 0", o_left_out,
                     o_right_out, o_locked, o_sample_strobe, o_frame_err);
        end
        rst_n = 1'b1;
        s0 = strb_cnt;
        for (int i = 9; i >= 1; i--) send_bit(1'b0, v[i]);
        send_bit(1'b1, v[0]);
        send_word(1'b1, 32'h4321, 16);
        checks++;
        if (strb_cnt - s0 !== 0 || o_left_out !== '0) begin
            errors++;
            $display("FAIL rstmid_partial got strb %0d left %h exp 0 0",
                     strb_cnt - s0, o_left_out);
        end
        send_frame(32'h7E57, 16, 32'h0BAD, 16);
        checks++;
        if (strb_cnt - s0 !== 1 || o_left_out !== 16'h7E57 ||
            o_right_out !== 16'h0BAD) begin
            errors++;
            $display("FAIL rstmid_pair got strb %0d %h %h exp 1 7e57 0bad",
                     strb_cnt - s0, o_left_out, o_right_out);
        end
    endtask

`ifdef I2S_RX_MONO_EN
    task automatic test_mono;
        send_frame(32'h7FFF, 16, 32'h7FFF, 16);
        checks++;
        if (o_mono_out !== 16'h7FFF) begin
            errors++; $display("FAIL mono_pos got %h exp 7fff", o_mono_out);
        end
        send_frame(32'h8000, 16, 32'h7FFF, 16);
        checks++;
        if (o_mono_out !== 16'hFFFF) begin
            errors++; $display("FAIL mono_mix got %h exp ffff", o_mono_out);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        strb_cnt = 0;
        ferr_cnt = 0;
        last_slat = 0;
        last_flat = 0;
        test_reset();
        test_nominal();
        test_random();
        test_bad_words();
        test_timeout();
        test_midword_start();
        test_reset_midword();
`ifdef I2S_RX_MONO_EN
        test_mono();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter WIDTH, default 16, sets the sample word width in bits.
REQ-002 Parameter TIMEOUT, default 255, sets the number of clk cycles without a BCK rising edge before lock is lost.
REQ-003 clk  input  1  system clock; at least 4x BCK frequency; all logic runs on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 i2s_bck  input  1  I2S bit clock; asynchronous to clk.
REQ-006 i2s_ws  input  1  I2S word select (0 = left, 1 = right); asynchronous.
REQ-007 i2s_din  input  1  I2S serial data, MSB first; asynchronous.
REQ-008 left_out  output  WIDTH  last complete left sample, two's complement.
REQ-009 right_out  output  WIDTH  last complete right sample, two's complement.
REQ-010 sample_strobe  output  1  one-clk pulse when left_out and right_out have both updated.
REQ-011 locked  output  1  high while a valid, error-free stereo stream is being received.
REQ-012 frame_err  output  1  one-clk pulse when a completed word has a bit count not equal to WIDTH.

Function
REQ-013 Input synchronisation:
- i2s_bck, i2s_ws and i2s_din each pass through a 2-FF synchroniser.
- A BCK rising edge is detected when the synchronised BCK is 1 and its previous value was 0.
REQ-014 At each detected BCK edge the block samples the synchronised din and ws; no other cycle samples data.
REQ-015 Framing is Philips I2S (one-bit delay):
- The edge at which the sampled ws differs from the previous sampled ws (ws_prev) carries the LSB of the word for channel ws_prev.
- That edge completes the word for channel ws_prev.
- The following edge carries the MSB of the new word.
REQ-016 The state machine has two states, HUNT and RUN; the reset state is HUNT.
REQ-017 In HUNT:
- Bits are discarded.
- On a ws 1->0 transition edge the bit counter and shift register clear and the state moves to RUN.
REQ-018 In RUN, each edge shifts din into the shift register and increments a saturating bit counter.
REQ-019 On word completion:
- More than WIDTH bits: keep the first WIDTH received.
- Fewer than WIDTH bits: left-justify and zero-pad.
- Any count not equal to WIDTH: pulse frame_err.
REQ-020 A completed left word goes to a staging register; it does not change the outputs.
REQ-021 A completed right word that directly follows a staged left word in the same RUN period:
- updates left_out (from staging) and right_out together;
- pulses sample_strobe one clk after the detection cycle.
REQ-022 Latency from a BCK rising edge at the pin to sample_strobe is 4 clk cycles.
REQ-023 A right word with no preceding staged left word updates nothing and produces no strobe.
REQ-024 locked rises with the first sample_strobe whose pair had no frame_err.
REQ-025 locked falls, and the state returns to HUNT, on either of:
- frame_err;
- TIMEOUT clk cycles without a BCK edge (watchdog reloads on every edge).
The staging register is invalidated in both cases.
REQ-026 If frame_err and a watchdog timeout occur in the same cycle, both pulse/act; the state goes to HUNT once.
REQ-027 left_out and right_out hold their values when lock is lost.

Reset
REQ-028 Reset values while rst_n is low, on a clk edge:
- left_out = 0, right_out = 0
- sample_strobe = 0, frame_err = 0, locked = 0
- state = HUNT
- synchronisers, counters and staging cleared
REQ-029 A reset mid-word discards the partial word; no strobe occurs until a fresh HUNT->RUN cycle and a full left/right pair.

Configuration
REQ-030 With I2S_RX_MONO_EN defined, there is an extra output mono_out (WIDTH):
- value is (left + right) arithmetic-shifted right by 1, using a WIDTH+1-bit sum;
- updates in the same cycle as left_out/right_out;
- resets to 0.
Without the macro the port and its logic do not exist.

Structure
REQ-031 Package i2s_pkg holds:
- the default WIDTH and TIMEOUT constants;
- the HUNT/RUN state enum typedef.
REQ-032 Sub-module i2s_rx_sync holds the 2-FF synchronisers and the BCK edge detector; everything else stays in i2s_rx.

Verification
REQ-033 Nominal stream: BCK = clk/22, 16-bit frames, left 0x1234, right 0xFEDC
-> after the second pair, left_out = 0x1234, right_out = 0xFEDC, one strobe per frame, locked = 1.
REQ-034 Short word: right word of 12 bits, 0xABC
-> right_out = 0xABC0, frame_err pulses, locked = 0, state = HUNT, no strobe for that frame.
REQ-035 BCK stops for 300 clk while locked
-> locked falls at TIMEOUT + 1 cycles after the last edge; outputs hold.
REQ-036 Start mid-right-word after reset
-> no update until the first complete left/right pair; the first strobe carries that pair.
REQ-037 rst_n asserted for 1 clk mid left word
-> all outputs 0 the next cycle; the partial word is never emitted.
REQ-038 With I2S_RX_MONO_EN: left 0x7FFF, right 0x7FFF -> mono_out = 0x7FFF; left 0x8000, right 0x7FFF -> mono_out = 0xFFFF.
